sync_filter: RTL

//  Multi-channel single-clock input conditioner and NUMSTGS-deep synchroniser.

---
 rtl/sync_pkg.sv | 9 +
 rtl/sync_filter_chan.sv | 64 ++++++
 rtl/sync_filter.sv | 49 ++++
 3 files changed

// File: rtl/sync_pkg.sv
// Shared helpers for the sync_filter block.
package sync_pkg;

    // Width of a counter that must hold values 0 .. filt_cyc.
    function automatic int cnt_w(input int filt_cyc);
        return $clog2(filt_cyc + 1);
    endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// One channel of sync_filter: flop-chain synchroniser, persistence filter on
// the synchronised level, and registered rise/fall pulses on accepted changes.
module sync_filter_chan
    import sync_pkg::*;
#(
    parameter int   NUMSTGS  = 2,
    parameter int   FILT_CYC = 4,
    parameter logic RST_BIT  = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic data_in,
    output logic data_sync,
    output logic data_out,
    output logic rise,
    output logic fall,
    output logic chg_nxt
);

    localparam int            CW     = cnt_w(FILT_CYC);
    localparam logic [CW-1:0] CNT_TC = CW'(FILT_CYC - 1);

    logic [NUMSTGS-1:0] stg;
    logic [CW-1:0]      cnt;
    logic               accept;

    // Synchroniser chain; stage 0 is the only flop that sees the async pin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stg <= {NUMSTGS{RST_BIT}};
        end else begin
            stg <= {stg[NUMSTGS-2:0], data_in};
        end
    end

    assign data_sync = stg[NUMSTGS-1];

    // The new level has now been seen for FILT_CYC consecutive edges.
    assign accept  = (data_sync != data_out) && (cnt == CNT_TC);
    // Lets the top register its OR so chg_any lines up with rise/fall.
    assign chg_nxt = accept;

    // Persistence counter, filtered level and edge pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            data_out <= RST_BIT;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            rise <= accept & data_sync;
            fall <= accept & ~data_sync;
            if (accept) begin
                data_out <= data_sync;
                cnt      <= '0;
            end else if (data_sync == data_out) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sync_filter.sv
// Multi-channel synchroniser plus glitch filter for slow async sideband pins.
// Each channel is independent; chg_any flags any accepted change this cycle.
module sync_filter
    import sync_pkg::*;
#(
    parameter int             NCH      = 4,
    parameter int             NUMSTGS  = 2,
    parameter int             FILT_CYC = 4,
    parameter logic [NCH-1:0] RST_VAL  = '0
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [NCH-1:0] data_in,
    output logic [NCH-1:0] data_sync,
    output logic [NCH-1:0] data_out,
    output logic [NCH-1:0] rise,
    output logic [NCH-1:0] fall,
    output logic           chg_any
);

    logic [NCH-1:0] chg_nxt;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        sync_filter_chan #(
            .NUMSTGS  (NUMSTGS),
            .FILT_CYC (FILT_CYC),
            .RST_BIT  (RST_VAL[i])
        ) u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .data_in   (data_in[i]),
            .data_sync (data_sync[i]),
            .data_out  (data_out[i]),
            .rise      (rise[i]),
            .fall      (fall[i]),
            .chg_nxt   (chg_nxt[i])
        );
    end

    // Registered from the channels' accept terms so it pulses with rise/fall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chg_any <= 1'b0;
        end else begin
            chg_any <= |chg_nxt;
        end
    end

endmodule
